// File: rtl/sm_debug_panel_if.sv
// Board-side bundle of the debug panel: raw keys and register data in,
// register address, page index and LED drive out.
interface sm_debug_panel_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LED_WIDTH  = 4,
    parameter int ADDR_WIDTH = 5
);
    localparam int NUM_PAGES  = DATA_WIDTH / LED_WIDTH;
    localparam int PAGE_WIDTH = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;

    logic                  key_addr;
    logic                  key_page;
    logic [DATA_WIDTH-1:0] regData;
    logic [ADDR_WIDTH-1:0] regAddr;
    logic [PAGE_WIDTH-1:0] page;
    logic [LED_WIDTH-1:0]  led;

    modport master (
        input  key_addr, key_page, regData,
        output regAddr, page, led
    );

    modport slave (
        output key_addr, key_page, regData,
        input  regAddr, page, led
    );
endinterface

// File: rtl/sm_debug_panel.sv
// SchoolMIPS board debug panel: two debounced keys step the register address
// and the displayed data slice; LEDs show the slice or, briefly, the new address.
module sm_debug_key #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic press
);
    localparam int CNT_WIDTH = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]           sync;
    logic                 s;
    logic                 clean;
    logic                 clean_last;
    logic [CNT_WIDTH-1:0] cnt;

    assign s = sync[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync       <= 2'b11;
            clean      <= 1'b1;
            clean_last <= 1'b1;
            cnt        <= '0;
            press      <= 1'b0;
        end else begin
            sync       <= {sync[0], key};
            clean_last <= clean;
            // one-cycle pulse on the debounced falling edge only
            press      <= clean_last & ~clean;
            if (s == clean) begin
                cnt <= '0;
            end else if (cnt == CNT_WIDTH'(DEBOUNCE_CYCLES - 1)) begin
                clean <= s;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module sm_debug_panel #(
    parameter int DATA_WIDTH      = 32,
    parameter int LED_WIDTH       = 4,
    parameter int ADDR_WIDTH      = 5,
    parameter int ADDR_RESET      = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SHOW_CYCLES     = 50000000,
    parameter int LED_ACTIVE_LOW  = 1
) (
    input  logic               clkIn,
    input  logic               rst_n,
    sm_debug_panel_if.master   bus
);
    localparam int NUM_KEYS    = 2;
    localparam int NUM_PAGES   = DATA_WIDTH / LED_WIDTH;
    localparam int PAGE_WIDTH  = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
    localparam int TIMER_WIDTH = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [LED_WIDTH-1:0] LED_MASK = {LED_WIDTH{(LED_ACTIVE_LOW != 0)}};

    typedef enum logic {SHOW_DATA, SHOW_ADDR} state_t;

    logic [NUM_KEYS-1:0] keys;
    logic [NUM_KEYS-1:0] press;
    logic                addr_press;
    logic                page_press;

    state_t                          state;
    logic [TIMER_WIDTH-1:0]          timer;
    logic [ADDR_WIDTH-1:0]           addr_q;
    logic [PAGE_WIDTH-1:0]           page_q;
    logic [LED_WIDTH-1:0]            led_q;
    logic [LED_WIDTH-1:0]            addr_led;
    logic [LED_WIDTH-1:0]            content;
    logic [NUM_PAGES-1:0][LED_WIDTH-1:0] slices;

    assign keys = {bus.key_page, bus.key_addr};

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        sm_debug_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
            .clk   (clkIn),
            .rst_n (rst_n),
            .key   (keys[i]),
            .press (press[i])
        );
    end

    // address key has priority when both pulses land on the same cycle
    assign addr_press = press[0];
    assign page_press = press[1] & ~press[0];

    if (ADDR_WIDTH >= LED_WIDTH) begin : g_addr_trunc
        assign addr_led = addr_q[LED_WIDTH-1:0];
    end else begin : g_addr_ext
        assign addr_led = {{(LED_WIDTH - ADDR_WIDTH){1'b0}}, addr_q};
    end

    assign slices = bus.regData;

    always_comb begin
        content = slices[page_q];
        if (state == SHOW_ADDR) content = addr_led;
    end

    always_ff @(posedge clkIn) begin
        if (!rst_n) begin
            state  <= SHOW_DATA;
            timer  <= '0;
            addr_q <= ADDR_WIDTH'(ADDR_RESET);
            page_q <= '0;
            led_q  <= LED_MASK;
        end else begin
            led_q <= content ^ LED_MASK;

            if (addr_press) begin
                addr_q <= addr_q + 1'b1;
                page_q <= '0;
            end else if (page_press) begin
                if (page_q == PAGE_WIDTH'(NUM_PAGES - 1)) page_q <= '0;
                else                                      page_q <= page_q + 1'b1;
            end

            case (state)
                SHOW_DATA: begin
                    if (addr_press) begin
                        state <= SHOW_ADDR;
                        timer <= TIMER_WIDTH'(SHOW_CYCLES - 1);
                    end
                end
                SHOW_ADDR: begin
                    if (addr_press)       timer <= TIMER_WIDTH'(SHOW_CYCLES - 1);
                    else if (page_press)  state <= SHOW_DATA;
                    else if (timer == '0) state <= SHOW_DATA;
                    else                  timer <= timer - 1'b1;
                end
                default: state <= SHOW_DATA;
            endcase
        end
    end

    assign bus.regAddr = addr_q;
    assign bus.page    = page_q;
    assign bus.led     = led_q;
endmodule

// File: tb/tb_sm_debug_panel.sv
// Randomised scoreboard bench for sm_debug_panel: an event-level model predicts
// led/regAddr/page after every edge and a monitor compares on the falling edge.
module tb_sm_debug_panel;
    localparam int D  = 4;
    localparam int S  = 8;
    localparam int DW = 32;
    localparam int LW = 4;
    localparam int AW = 5;

    typedef struct {
        logic [3:0] led;
        logic [4:0] addr;
        logic [2:0] page;
    } exp_t;

    logic clkIn = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clkIn = ~clkIn;

    sm_debug_panel_if #(.DATA_WIDTH(DW), .LED_WIDTH(LW), .ADDR_WIDTH(AW)) bus ();

    sm_debug_panel #(
        .DATA_WIDTH(DW), .LED_WIDTH(LW), .ADDR_WIDTH(AW), .ADDR_RESET(2),
        .DEBOUNCE_CYCLES(D), .SHOW_CYCLES(S), .LED_ACTIVE_LOW(1)
    ) dut (
        .clkIn (clkIn),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: a key is accepted once its synchronised level has
    // disagreed with the accepted level for D samples in a row; the effect
    // lands two edges later. Address display is tracked as a deadline.
    initial begin : model
        int         cyc;
        int         show_end;
        int         pend[2];
        bit         show;
        bit         clean[2];
        bit         r1[2];
        bit         r2[2];
        bit         s;
        bit         ap;
        bit         pp;
        logic [D-1:0] shv[2];
        logic [1:0] kin;
        logic [31:0] rd;
        logic [4:0] addr;
        logic [2:0] page;
        logic [3:0] eled;
        exp_t       e;
        cyc = 0; show_end = 0; show = 0; addr = 5'd2; page = 3'd0; eled = 4'hF;
        for (int i = 0; i < 2; i++) begin
            pend[i] = -1; clean[i] = 1; r1[i] = 1; r2[i] = 1; shv[i] = '1;
        end
        forever begin
            @(posedge clkIn);
            cyc++;
            if (!rst_n) begin
                addr = 5'd2; page = 3'd0; show_end = 0; show = 0; eled = 4'hF;
                for (int i = 0; i < 2; i++) begin
                    pend[i] = -1; clean[i] = 1; r1[i] = 1; r2[i] = 1; shv[i] = '1;
                end
            end else begin
                rd   = bus.regData;
                eled = show ? ~addr[3:0] : ~rd[page*4 +: 4];
                kin  = {bus.key_page, bus.key_addr};
                for (int i = 0; i < 2; i++) begin
                    s      = r2[i];
                    r2[i]  = r1[i];
                    r1[i]  = kin[i];
                    shv[i] = {shv[i][D-2:0], s};
                end
                ap = (pend[0] == cyc);
                pp = (pend[1] == cyc);
                if (ap) begin
                    addr     = addr + 5'd1;
                    page     = 3'd0;
                    show_end = cyc + S;
                end else if (pp) begin
                    page = 3'((page + 1) % 8);
                    if (show) show_end = cyc;
                end
                for (int i = 0; i < 2; i++) begin
                    if (shv[i] == {D{~clean[i]}}) begin
                        clean[i] = ~clean[i];
                        if (!clean[i]) pend[i] = cyc + 2;
                    end
                end
                show = (cyc < show_end);
            end
            e.led = eled; e.addr = addr; e.page = page;
            sb.push_back(e);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clkIn);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("led",     32'(bus.led),     32'(e.led));
                chk("regAddr", 32'(bus.regAddr), 32'(e.addr));
                chk("page",    32'(bus.page),    32'(e.page));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: bench did not finish, got=running expected=done");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic ka, input logic kp, input int n);
        bus.key_addr = ka;
        bus.key_page = kp;
        repeat (n) @(negedge clkIn);
    endtask

    task automatic tap(input logic ka, input logic kp);
        drive(ka, kp, 8);
        drive(1'b1, 1'b1, 8);
    endtask

    initial begin : stimulus
        int n;
        bus.key_addr = 1'b1;
        bus.key_page = 1'b1;
        bus.regData  = 32'h89ABCDE5;
        @(negedge clkIn);
        repeat (3) @(negedge clkIn);
        rst_n = 1'b1;
        drive(1, 1, 4);

        // page step, short glitch ignored, then wrap after 8 steps
        drive(1, 0, 20);
        drive(1, 1, 10);
        drive(1, 0, 3);
        drive(1, 1, 10);
        repeat (7) tap(1, 0);

        // address step with display window, and a restart inside the window
        drive(0, 1, 8);
        drive(1, 1, 14);
        drive(0, 1, 8);
        drive(1, 1, 3);
        drive(0, 1, 8);
        drive(1, 1, 16);
        repeat (28) tap(0, 1);

        // simultaneous presses from page 5, then page press inside address window
        repeat (5) tap(1, 0);
        drive(0, 0, 8);
        drive(1, 1, 3);
        drive(1, 0, 8);
        drive(1, 1, 10);

        // reset while in address window with a press partly debounced
        drive(0, 1, 8);
        drive(1, 1, 3);
        drive(0, 1, 5);
        rst_n = 1'b0;
        drive(0, 1, 2);
        rst_n = 1'b1;
        drive(0, 1, 12);
        drive(1, 1, 12);

        for (int it = 0; it < 300; it++) begin
            bus.regData = $urandom();
            n = $urandom_range(1, 10);
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 3));
                rst_n = 1'b1;
            end
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), n);
        end
        drive(1, 1, 20);

        n = 0;
        while (sb.size() > 1 && n < 20) begin
            @(negedge clkIn);
            n++;
        end
        chk("scoreboard_drained", 32'(sb.size() <= 1), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
